// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit between execute stage and a request/acknowledge data memory
//
// Purpose: accepts one load or store at a time. It drives little-endian byte
// lanes and replicates store data across the bus. Sub-word load data is sign-
// or zero-extended. The unit waits for mem_ack for at most MAX_WAIT cycles.
// Illegal requests (load and store together, misaligned, dword on a 32-bit bus)
// complete with an error and make no memory access.
//
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   ld_ena, st_ena       load / store request, sampled in IDLE only
//   size, sign_ext       access size (0 byte .. 3 dword), load extension mode
//   address_in, data_in  byte address, right-aligned store data
//   data_out             last successful load result, extended and right-aligned
//   busy, done, error    in-flight flag, completion pulse, error pulse (with done)
//   mem_*                memory request port; mem_rdata is valid with mem_ack
module load_store_unit #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 ld_ena,
   input  logic                 st_ena,
   input  logic [1:0]           size,
   input  logic                 sign_ext,
   input  logic [ADDR_W-1:0]    address_in,
   input  logic [WIDTH-1:0]     data_in,
   output logic [WIDTH-1:0]     data_out,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [WIDTH-1:0]     mem_wdata,
   output logic [WIDTH/8-1:0]   mem_be,
   output logic                 mem_req,
   output logic                 mem_we,
   input  logic                 mem_ack,
   input  logic [WIDTH-1:0]     mem_rdata
);
   localparam int NB = WIDTH / 8;
   localparam int LB = $clog2(NB);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Counter value on the last allowed REQ cycle without ack.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic              st_q, st_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [WIDTH-1:0]  dout_q, dout_d;

   logic              misaligned, illegal;
   logic [LB-1:0]     lane;
   logic [NB-1:0]     be_lanes;
   logic [WIDTH-1:0]  wdata_rep, rd_shift, ext_mask, load_ext;
   logic              ext_neg;

   always_comb begin
      case (size)
         2'd1:    misaligned = address_in[0];
         2'd2:    misaligned = |address_in[1:0];
         2'd3:    misaligned = |address_in[2:0];
         default: misaligned = 1'b0;
      endcase
      illegal = (ld_ena && st_ena) || misaligned || (size == 2'd3 && WIDTH == 32);
   end

   // Lane, store replication and load extension all work from the latched
   // request, so the memory-side values stay stable for the whole REQ phase.
   assign lane = addr_q[LB-1:0];

   always_comb begin
      rd_shift = mem_rdata >> {lane, 3'b000};
      case (size_q)
         2'd0: begin
            be_lanes  = NB'(1) << lane;
            wdata_rep = {NB{wdata_q[7:0]}};
            ext_mask  = WIDTH'(8'hFF);
            ext_neg   = rd_shift[7];
         end
         2'd1: begin
            be_lanes  = NB'(2'b11) << lane;
            wdata_rep = {(WIDTH/16){wdata_q[15:0]}};
            ext_mask  = WIDTH'(16'hFFFF);
            ext_neg   = rd_shift[15];
         end
         2'd2: begin
            be_lanes  = NB'(4'hF) << lane;
            wdata_rep = {(WIDTH/32){wdata_q[31:0]}};
            ext_mask  = WIDTH'(32'hFFFF_FFFF);
            ext_neg   = rd_shift[31];
         end
         default: begin
            be_lanes  = '1;
            wdata_rep = wdata_q;
            ext_mask  = '1;
            ext_neg   = 1'b0;
         end
      endcase
      // A full-width access has an all-ones mask, so it passes through unchanged.
      load_ext = (rd_shift & ext_mask) | ((sign_q && ext_neg) ? ~ext_mask : '0);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      sign_d  = sign_q;
      st_d    = st_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      case (state_q)
         S_IDLE: begin
            if (ld_ena || st_ena) begin
               size_d  = size;
               sign_d  = sign_ext;
               st_d    = st_ena;
               addr_d  = address_in;
               wdata_d = data_in;
               err_d   = illegal;
               cnt_d   = 8'd0;
               state_d = illegal ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            // An ack on the final wait cycle takes priority over the timeout.
            if (mem_ack) begin
               if (!st_q) dout_d = load_ext;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == WAIT_LAST) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            cnt_d   = 8'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         size_q  <= 2'd0;
         sign_q  <= 1'b0;
         st_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         st_q    <= st_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
      end
   end

   assign busy      = (state_q == S_REQ);
   assign done      = (state_q == S_DONE);
   assign error     = done && err_q;
   assign mem_req   = busy;
   assign mem_we    = busy && st_q;
   assign mem_be    = busy ? be_lanes : '0;
   assign mem_addr  = addr_q & ~ADDR_W'(NB - 1);
   assign mem_wdata = wdata_rep;
   assign data_out  = dout_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit between the CPU execute/memory stage and the data memory port. Generalises the single-cycle load gating block: it accepts load and store requests, drives byte lanes, sign- or zero-extends sub-word load data and handshakes with a variable-latency memory through a request/acknowledge protocol. It adds misalignment and timeout detection, and drives defined idle values in place of tri-states.

## Interface
- WIDTH, 32: data bus width; must be 32 or 64.
- ADDR_W, 32: address width.
- MAX_WAIT, 15: maximum request cycles without `mem_ack` before timeout; range 1..255.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- ld_ena  in  1  load request; sampled in IDLE only.
- st_ena  in  1  store request; sampled in IDLE only.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when WIDTH = 64).
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- address_in  in  ADDR_W  byte address.
- data_in  in  WIDTH  store data, right-aligned.
- data_out  out  WIDTH  extended, right-aligned load result.
- busy  out  1  high from accept until the cycle before `done`.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle error pulse, asserted together with `done`.
- mem_addr  out  ADDR_W  word-aligned address; low log2(WIDTH/8) bits are 0.
- mem_wdata  out  WIDTH  store data replicated across lanes.
- mem_be  out  WIDTH/8  byte enables.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_ack  in  1  memory completion; read data is valid on `mem_rdata` in the same cycle.
- mem_rdata  in  WIDTH  memory read data.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE, nothing requested.** If neither `ld_ena` nor `st_ena` is high, stay in IDLE.
- **IDLE, request present.** If `ld_ena` or `st_ena` is high, latch `size`, `sign_ext`, the address, the store data and the operation type.
  - If the request is illegal, go to DONE with the error flag set and issue no memory access. A request is illegal when:
    - `ld_ena` and `st_ena` are both high;
    - the access is misaligned (half with addr[0] ≠ 0, word with addr[1:0] ≠ 0, dword with addr[2:0] ≠ 0);
    - `size` = 3 while WIDTH = 32.
  - Otherwise go to REQ.
- **REQ.**
  - `mem_req` = 1; `mem_we` = 1 for stores.
  - `mem_addr`, `mem_be` and `mem_wdata` are driven from the latched values and stay stable until `mem_ack`.
  - On `mem_ack`: for loads, capture the extended result into `data_out`, then go to DONE.
  - The wait counter increments each REQ cycle without ack. When it reaches MAX_WAIT, go to DONE with the error flag set; `data_out` is unchanged.
- **DONE.** Pulse `done` (plus `error` if the flag is set), clear the counter, return to IDLE.
- **Lane mapping (little-endian).** Lane k = address bits [log2(WIDTH/8)-1:0].
  - Byte: `mem_be` = 1 << k.
  - Half: lanes k, k+1.
  - Word: 4 lanes starting at k.
  - Dword: all lanes.
- **Store data.** `mem_wdata` replicates the low byte (byte), low half (half) or low word (word) across the bus.
- **Load data.** Selected from lane k and sign- or zero-extended to WIDTH. A word load with WIDTH = 32 is passed through unchanged.
- **Holding and idle values.**
  - `data_out` holds the last successful load result; stores and errors do not change it.
  - Outside REQ: `mem_req`, `mem_we` and `mem_be` are 0. `mem_addr` and `mem_wdata` are don't-care but must not be X; drive the latched values.
- `ld_ena`/`st_ena` are ignored while busy; the requester must re-assert them after `done`.

## Timing
- **Reset (asynchronous, any state, including mid-REQ).**
  - State returns to IDLE; the counter clears.
  - `data_out`, `mem_addr`, `mem_wdata` and `mem_be` go to 0.
  - `mem_req`, `mem_we`, `busy`, `done` and `error` go to 0.
  - An in-flight memory access is abandoned.
- **Normal latency.** Accept at edge 0; `mem_req` is high from edge 0. If `mem_ack` is seen at edge 1, `done` is high in the cycle after edge 1. Latency = 2 + number of wait cycles.
- **Illegal request.** `done`/`error` are high in the cycle after the accept edge; `mem_req` never rises.
- **Timeout.** `mem_req` stays high for exactly MAX_WAIT cycles, then `done`/`error` pulse.
- **Ack on the final wait cycle.** If `mem_ack` arrives in the same cycle the counter reaches MAX_WAIT, the ack wins: the access succeeds with no error.
- **Throughput.** A new request can be accepted in the cycle after `done`.

## Test plan
- **Byte load, sign-extended, zero wait.** Load, size 0, sign_ext 1, address 0x1003, `mem_rdata` = 0x80112233, ack in the first REQ cycle. Required: `mem_be` = 4'b1000, `mem_addr` = 0x1000, `data_out` = 0xFFFFFF80, `done` 2 cycles after accept.
- **Half store, 3 wait cycles.** Store, size 1, address 0x2002, `data_in` = 0x0000BEEF, ack after 3 wait cycles. Required: `mem_be` = 4'b1100, `mem_wdata` = 0xBEEFBEEF, `mem_we` = 1, `done` 5 cycles after accept, `error` = 0.
- **Misaligned word load.** Load, size 2, address 0x3001. Required: `mem_req` stays 0, `done` = `error` = 1 one cycle after accept, `data_out` unchanged.
- **Timeout with MAX_WAIT = 4.** Ack never arrives. Required: `mem_req` high for 4 cycles, then the `done`/`error` pulse. Also cover ack arriving on cycle 4: success, no error.
- **Simultaneous `ld_ena` and `st_ena`.** Required: error pulse, no memory access.
- **Reset mid-REQ.** Deassert `reset_n` in the second REQ cycle. Required: all outputs 0 immediately (asynchronously). After release, a byte zero-extended load from 0x0 with `mem_rdata` = 0x000000AB gives `data_out` = 0x000000AB.
